// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, BITS_PER_CYCLE full-subtractor cells per clock,
// borrow carried between cycles in a flop, start/done handshake with signed-overflow flag.
module serial_subtractor #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          sa_q, sa_d;
  logic [WIDTH-1:0]          sb_q, sb_d;
  logic [WIDTH-1:0]          sd_q, sd_d;
  logic                      br_q, br_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      a_msb_q, a_msb_d;
  logic                      b_msb_q, b_msb_d;
  logic [WIDTH-1:0]          diff_q, diff_d;
  logic                      bout_q, bout_d;
  logic                      ovf_q, ovf_d;

  logic [BITS_PER_CYCLE-1:0] step_bits;
  logic                      borrow_c;
  logic [WIDTH-1:0]          sd_shift;

  // Ripple of full-subtractor cells over the low slice of the operand shift registers.
  always_comb begin
    borrow_c  = br_q;
    step_bits = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      step_bits[k] = sa_q[k] ^ sb_q[k] ^ borrow_c;
      borrow_c     = (~sa_q[k] & sb_q[k]) | (~(sa_q[k] ^ sb_q[k]) & borrow_c);
    end
    sd_shift = sd_q >> BITS_PER_CYCLE;
    sd_shift[WIDTH-1 -: BITS_PER_CYCLE] = step_bits;
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          sd_d    = '0;
          br_d    = bin;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> BITS_PER_CYCLE;
        sb_d  = sb_q >> BITS_PER_CYCLE;
        sd_d  = sd_shift;
        br_d  = borrow_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          // Results are exposed only here, so outputs never show a partial difference.
          diff_d  = sd_shift;
          bout_d  = borrow_c;
          ovf_d   = (a_msb_q ^ b_msb_q) & (sd_shift[WIDTH-1] ^ a_msb_q);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed table, handshake/reset sequences, random ops against
// an arithmetic model, and an exhaustive WIDTH=4 sweep over three BITS_PER_CYCLE settings.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  logic       start4, bin4;
  logic [3:0] a4, b4;
  logic [2:0] busy4, done4, bout4, ovf4;
  logic [3:0] diff4 [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8));

  serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(1)) u_dut4_1 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4[0]), .done(done4[0]), .diff(diff4[0]), .bout(bout4[0]), .ovf(ovf4[0]));

  serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(2)) u_dut4_2 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4[1]), .done(done4[1]), .diff(diff4[1]), .bout(bout4[1]), .ovf(ovf4[1]));

  serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(4)) u_dut4_4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4[2]), .done(done4[2]), .diff(diff4[2]), .bout(bout4[2]), .ovf(ovf4[2]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int w, input int ia, input int ib, input int ibin,
                                output int d, output int bo, output int ov);
    int m, r, sa, sb, sr;
    m  = 1 << w;
    r  = ia - ib - ibin;
    d  = (r + m) % m;
    bo = (r < 0) ? 1 : 0;
    sa = (ia >= m / 2) ? ia - m : ia;
    sb = (ib >= m / 2) ? ib - m : ib;
    sr = sa - sb - ibin;
    ov = (sr < -(m / 2) || sr >= m / 2) ? 1 : 0;
  endfunction

  // Called just after a rising edge; returns once done is seen or the cycle budget expires.
  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        output int lat, output int busy_cnt, output logic got_done);
    start8 = 1'b1; a8 = ta; b8 = tb; bin8 = tbin;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    lat = 0; busy_cnt = 0; got_done = 1'b0;
    while (!got_done && lat < 40) begin
      if (done8) got_done = 1'b1;
      else begin
        if (busy8) busy_cnt++;
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bcnt, d, bo, ov, ndone, t;
    logic gd;
    logic [7:0] ra, rb;
    logic rbin;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[7] = '{8'hC8, 8'h64, 1'b1, 8'h63, 1'b0, 1'b1};

    reset = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    chk("reset_diff", diff8, 0);
    chk("reset_bout", bout8, 0);
    chk("reset_ovf", ovf8, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      do_op8(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bcnt, gd);
      chk($sformatf("vec%0d_done", i), gd, 1);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
      chk($sformatf("vec%0d_busy_in_done", i), busy8, 0);
      chk($sformatf("vec%0d_diff", i), diff8, vecs[i].diff);
      chk($sformatf("vec%0d_bout", i), bout8, vecs[i].bout);
      chk($sformatf("vec%0d_ovf", i), ovf8, vecs[i].ovf);
    end

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      model(8, ra, rb, rbin, d, bo, ov);
      do_op8(ra, rb, rbin, lat, bcnt, gd);
      chk("rand_latency", lat, 8);
      chk("rand_diff", diff8, d);
      chk("rand_bout", bout8, bo);
      chk("rand_ovf", ovf8, ov);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // start pulsed mid-RUN must be ignored
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0; d = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin start8 = 1'b1; a8 = 8'h40; b8 = 8'h11; end
      else start8 = 1'b0;
      @(posedge clk); #1;
      if (done8) begin ndone++; d = diff8; end
    end
    chk("busy_start_done_count", ndone, 1);
    chk("busy_start_diff", d, 8'h02);

    // start held through DONE: second op starts with no idle cycle
    start8 = 1'b1; a8 = 8'h20; b8 = 8'h05; bin8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'h10; b8 = 8'h20; bin8 = 1'b1;
    t = 0;
    while (!done8 && t < 40) begin @(posedge clk); #1; t++; end
    chk("held_first_latency", t, 8);
    chk("held_first_diff", diff8, 8'h1B);
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("held_no_idle_busy", busy8, 1);
    t = 1; bcnt = 0;
    while (!done8 && t < 40) begin
      if (busy8) bcnt++;
      @(posedge clk); #1; t++;
    end
    chk("held_done_spacing", t, 9);
    chk("held_busy_between", bcnt, 8);
    chk("held_second_diff", diff8, 8'hEF);
    chk("held_second_bout", bout8, 1);
    chk("held_second_ovf", ovf8, 0);
    @(posedge clk); #1;

    // reset in the middle of an operation
    do_op8(8'h80, 8'h01, 1'b0, lat, bcnt, gd);
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h0A; bin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_run_busy", busy8, 1);
    chk("mid_run_diff_held", diff8, 8'h7F);
    chk("mid_run_ovf_held", ovf8, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy", busy8, 0);
    chk("async_reset_done", done8, 0);
    chk("async_reset_diff", diff8, 0);
    chk("async_reset_bout", bout8, 0);
    chk("async_reset_ovf", ovf8, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    chk("aborted_no_done", ndone, 0);
    do_op8(8'h10, 8'h01, 1'b0, lat, bcnt, gd);
    chk("post_reset_latency", lat, 8);
    chk("post_reset_diff", diff8, 8'h0F);
    chk("post_reset_bout", bout8, 0);

    // exhaustive WIDTH=4 sweep
    for (int i = 0; i < 512; i++) begin
      int lat4 [3];
      int dg [3], bg [3], og [3], nd [3];
      int exp_lat [3];
      exp_lat[0] = 4; exp_lat[1] = 2; exp_lat[2] = 1;
      for (int k = 0; k < 3; k++) begin lat4[k] = 0; nd[k] = 0; dg[k] = 0; bg[k] = 0; og[k] = 0; end
      @(posedge clk); #1;
      start4 = 1'b1; a4 = 4'(i >> 5); b4 = 4'(i >> 1); bin4 = 1'(i);
      model(4, int'(a4), int'(b4), int'(bin4), d, bo, ov);
      @(posedge clk); #1;
      start4 = 1'b0; a4 = ~a4; b4 = ~b4; bin4 = ~bin4;
      for (int c = 1; c <= 6; c++) begin
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
          if (done4[k]) begin
            nd[k]++;
            if (lat4[k] == 0) begin
              lat4[k] = c; dg[k] = diff4[k]; bg[k] = bout4[k]; og[k] = ovf4[k];
            end
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("sweep%0d_bpc_idx%0d_latency", i, k), lat4[k], exp_lat[k]);
        chk($sformatf("sweep%0d_bpc_idx%0d_done_count", i, k), nd[k], 1);
        chk($sformatf("sweep%0d_bpc_idx%0d_diff", i, k), dg[k], d);
        chk($sformatf("sweep%0d_bpc_idx%0d_bout", i, k), bg[k], bo);
        chk($sformatf("sweep%0d_bpc_idx%0d_ovf", i, k), og[k], ov);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
